wr_stream_adapter: RTL
======================

WR_STREAM_ADAPTER -- requirements
Module: wr_stream_adapter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: FIFO address width; pointers are ADDR_WIDTH+1 bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width.
REQ-003 SHALL have parameter AF_THRESH, default 1020: almost-full level threshold, legal range 1..2^ADDR_WIDTH.
REQ-004 w_clk  input  1  write-domain clock; all logic on rising edge.
REQ-005 w_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_valid  input  1  upstream data valid.
REQ-007 s_data  input  DATA_WIDTH  upstream payload.
REQ-008 s_ready  output  1  adapter can accept a beat; registered.
REQ-009 w_full  input  1  full flag from the FIFO write-pointer block.
REQ-010 w_ptr_gray  input  ADDR_WIDTH+1  write pointer, Gray code, from the write-pointer block.
REQ-011 r_ptr_sync  input  ADDR_WIDTH+1  read pointer, Gray code, already synchronised into w_clk.
REQ-012 w_push  output  1  write request to the write-pointer block.
REQ-013 w_data  output  DATA_WIDTH  payload to FIFO RAM, valid when w_push=1.
REQ-014 w_level  output  ADDR_WIDTH+1  registered FIFO occupancy estimate.
REQ-015 w_afull  output  1  registered almost-full flag.

Function
REQ-016 SHALL contain a 2-entry skid buffer with states EMPTY, ONE, TWO.
REQ-017 accept = s_valid & s_ready; drain = w_push.
REQ-018 Transitions: EMPTY->ONE on accept; ONE->TWO on accept & !drain; ONE->EMPTY on drain & !accept; TWO->ONE on drain (accept impossible); otherwise hold.
REQ-019 Simultaneous accept and drain in ONE SHALL stay in ONE, head replaced by new beat, order preserved.
REQ-020 Order SHALL be strict FIFO; no beat dropped or duplicated.
REQ-021 s_ready SHALL be a flop, 1 in EMPTY and ONE, 0 in TWO, updated for the next-state value.
REQ-022 w_push = (state != EMPTY) & !w_full, combinational; w_push SHALL never be 1 while w_full=1.
REQ-023 w_data SHALL be the oldest buffered entry, a register output.
REQ-024 Latency: beat accepted in cycle N SHALL first appear on w_data with w_push eligible in cycle N+1.
REQ-025 Sustained throughput SHALL be one beat per cycle while w_full=0.
REQ-026 w_full asserting mid-stream SHALL hold the buffer; upstream stalls after at most one further accepted beat.
REQ-027 Level: Gray-to-binary convert both pointers; w_level <= wbin - rbin modulo 2^(ADDR_WIDTH+1), registered, 1-cycle latency from pointer inputs.
REQ-028 Pointer wrap-around SHALL yield correct level; range 0..2^ADDR_WIDTH.
REQ-029 w_afull <= (level_next >= AF_THRESH), registered with w_level.
REQ-030 Skid entries SHALL not be counted in w_level.

Reset
REQ-031 w_rst_n low SHALL asynchronously force state EMPTY, s_ready=0, w_level=0, w_afull=0, w_data=0.
REQ-032 s_ready SHALL rise on the first w_clk edge after w_rst_n deasserts.
REQ-033 Reset mid-operation SHALL discard buffered beats; w_push SHALL be 0 while in reset.

Configuration
REQ-034 Macro WR_STREAM_LEVEL_EN: defined -> level and almost-full logic per REQ-027..REQ-030.
REQ-035 Undefined -> no pointer-conversion logic, w_level tied 0, w_afull tied 0; w_ptr_gray and r_ptr_sync unused; skid behaviour unchanged.

Verification
REQ-036 After reset, s_valid=1 with data 0x1,0x2,0x3 back-to-back, w_full=0 -> w_push cycles 1..3 after first accept, w_data 0x1,0x2,0x3, s_ready stays 1.
REQ-037 w_full=1 held, 3 beats offered -> 2 accepted, s_ready=0 after second, w_push=0; w_full=0 -> both drained in order, s_ready=1.
REQ-038 w_full toggling every cycle, 100 random beats -> output sequence equals input sequence, w_push never high with w_full.
REQ-039 ADDR_WIDTH=4, AF_THRESH=14: w_ptr_gray=gray(14), r_ptr_sync=gray(0) -> next cycle w_level=14, w_afull=1; r_ptr_sync=gray(1) -> w_level=13, w_afull=0.
REQ-040 ADDR_WIDTH=4: w_ptr_gray=gray(3), r_ptr_sync=gray(29) -> w_level=6 (wrap).
REQ-041 w_rst_n pulsed low with state TWO -> immediately s_ready=0, w_push=0, w_level=0; resumes clean with no stale beats.

Source files
------------

// File: rtl/wr_stream_adapter.sv
`default_nettype none
// wr_stream_adapter: 2-entry skid buffer feeding an async-FIFO write port, rev 1.0.
// Define WR_STREAM_LEVEL_EN to build the registered occupancy/almost-full estimate.
module wr_stream_adapter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int AF_THRESH  = 1020
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  w_full,
  input  logic [ADDR_WIDTH:0]   w_ptr_gray,
  input  logic [ADDR_WIDTH:0]   r_ptr_sync,
  output logic                  w_push,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  w_afull
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  s_ready_q, s_ready_d;
  logic                  accept, drain;

  assign accept = s_valid & s_ready_q;
  assign drain  = w_push;
  assign w_push = (state_q != ST_EMPTY) & ~w_full;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          head_d  = s_data;
        end
      end
      ST_ONE: begin
        // Accept with drain keeps one entry: the new beat becomes the head.
        if (accept && drain) begin
          head_d = s_data;
        end else if (accept) begin
          state_d = ST_TWO;
          tail_d  = s_data;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_d = ST_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    s_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q   <= ST_EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready = s_ready_q;
  assign w_data  = head_q;

`ifdef WR_STREAM_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AF_THRESH);

  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  logic [ADDR_WIDTH:0] level_d, level_q;
  logic                afull_q;

  // Modular subtraction handles pointer wrap without extra logic.
  assign level_d = gray2bin(w_ptr_gray) - gray2bin(r_ptr_sync);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= (level_d >= AF_LVL);
    end
  end

  assign w_level = level_q;
  assign w_afull = afull_q;
`else
  logic unused_ptrs;
  assign unused_ptrs = ^{w_ptr_gray, r_ptr_sync};
  assign w_level     = '0;
  assign w_afull     = 1'b0;
`endif

endmodule
`default_nettype wire
